sw_hex_uart_tx: RTL and testbench
=================================

Name: sw_hex_uart_tx

Overview:
- Reports the board switch state over the serial `tx` line as printable text. It is the outbound counterpart to the switch/LED and `rx` input path.
- Samples the 16 `sw` inputs, detects any change, and transmits the new value as four uppercase hex digits followed by CR LF.
- Frame format is 8N1 UART at a fixed bit period.
- Sits at top level between `sw` and the `tx` pin, replacing the `rx`-to-`tx` loopback.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range is 2 or more.
- SYNC_STAGES, 2, flip-flop stages in the `sw` synchronizer; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  16  asynchronous switch inputs.
- send  input  1  single-cycle request to report `sw` even if unchanged; synchronous to `clk`.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high while a frame is being transmitted.
- sent_count  output  8  number of completed frames, mod 256.

Behaviour:
- Reset (asynchronous, `rst_n` low), all registered:
  - `tx`=1, `busy`=0, `sent_count`=0.
  - Synchronizer stages=0, `last_sent`=0, state=IDLE.
  - Reset takes effect immediately, including mid-frame; the frame is abandoned and not resumed.
- Input sampling:
  - `sw` passes through SYNC_STAGES flops to give `sync_sw`.
  - Change detection uses `sync_sw` only.
- Trigger:
  - Evaluated only in IDLE, at each rising edge.
  - Trigger = (`sync_sw` != `last_sent`) OR `send`.
  - On trigger: `snapshot` <= `sync_sw`, `last_sent` <= `sync_sw`, state <= START, char index <= 0, `busy` <= 1, `tx` <= 0.
  - `tx` and `busy` change on the same edge that sees the trigger.
  - A change and `send` in the same cycle produce exactly one frame.
- States: IDLE, START, DATA, STOP.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if char index < 5, increment it and go straight to START (no idle gap between characters). Otherwise go to IDLE.
- Character sequence (index 0..5), fixed per frame from `snapshot`:
  - Indices 0..3: nibbles [15:12], [11:8], [7:4], [3:0].
  - Each nibble is encoded as 0x30+n for n<10, or 0x41+(n-10) for n≥10.
  - Index 4: 0x0D. Index 5: 0x0A.
- Frame timing:
  - A frame is 60*CLKS_PER_BIT cycles.
  - `busy` is high for exactly that many cycles, then falls on the edge that enters IDLE.
  - That same edge increments `sent_count`, wrapping 255 to 0.
- Back-to-back frames:
  - IDLE lasts at least one cycle, so there is at least 1 idle cycle with `tx`=1 between frames.
  - The earliest next START is at that following edge.
- Changes during a frame:
  - `snapshot` is frozen; the current frame is unaffected.
  - Intermediate values are dropped. Only the value of `sync_sw` at the next IDLE evaluation is reported.
- `send` while `busy`=1 is ignored and not queued.
- Counters:
  - Bit-timer width is $clog2(CLKS_PER_BIT).
  - The bit timer restarts at 0 at the start of every bit, with no drift across characters.
- After reset release, if `sync_sw` != 0 the block sends a frame once the synchronizer settles.

Test Plan:
1. CLKS_PER_BIT=4, `sw`=0, no `send` for 500 cycles after reset -> `tx`=1, `busy`=0, `sent_count`=0 throughout.
2. CLKS_PER_BIT=4, `sw` set to 0xA5C3 -> bench UART model decodes 0x41 0x35 0x43 0x33 0x0D 0x0A. Each bit is exactly 4 cycles. `busy` is high for 240 cycles. `sent_count`=1. `tx` falls SYNC_STAGES+1 edges after the `sw` change.
3. `sw`=0x0000 steady, one-cycle `send` pulse -> frame "0000\r\n". `sent_count` increments by 1. A second `send` during that frame produces no extra frame.
4. `sw`=0x1111 starts a frame; mid-frame `sw`->0x2222, then ->0x3BEF before the frame ends -> first frame is "1111\r\n". After exactly 1 idle cycle, one frame "3BEF\r\n" follows. No "2222" frame is sent.
5. `rst_n` asserted during char index 2 -> `tx`=1, `busy`=0, `sent_count`=0 with no clock edge. Release with `sw`=0xFFFF -> a complete "FFFF\r\n" frame follows.
6. 256 `send` pulses, each issued after `busy` falls -> `sent_count` reads 0 at the end, and reads 255 after the 255th frame.

Source files
------------

// File: rtl/sw_hex_uart_tx.sv
// sw_hex_uart_tx: reports the 16 board switches over a UART tx line as text.
// When the synchronized switch value differs from the last value sent (or on a
// one-cycle `send` request), it transmits four uppercase hex digits plus CR LF,
// 8N1, CLKS_PER_BIT clocks per bit.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   sw         - asynchronous switch inputs
//   send       - single-cycle request to report sw even if unchanged
//   tx         - UART serial output, idles high
//   busy       - high while a frame is being transmitted
//   sent_count - completed frames, mod 256
module sw_hex_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  sent_count
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_CHAR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0]  sync_sw;
  logic [15:0]  snapshot_q;
  logic [15:0]  last_sent_q;
  state_e       state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]   bit_idx_q;
  logic [2:0]   char_idx_q;
  logic         tx_q;
  logic         busy_q;
  logic [7:0]   cnt_q;
  logic [7:0]   char_c;
  logic         trigger_c;
  logic [2:0]   next_bit_c;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Switch synchronizer; stage 0 captures the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
  end

  assign sync_sw    = sync_q[SYNC_STAGES-1];
  assign trigger_c  = (sync_sw != last_sent_q) || send;
  assign next_bit_c = bit_idx_q + 3'd1;

  // Character currently on the wire, chosen from the frozen snapshot.
  always_comb begin
    char_c = 8'h0A;
    unique case (char_idx_q)
      3'd0:    char_c = hex_ascii(snapshot_q[15:12]);
      3'd1:    char_c = hex_ascii(snapshot_q[11:8]);
      3'd2:    char_c = hex_ascii(snapshot_q[7:4]);
      3'd3:    char_c = hex_ascii(snapshot_q[3:0]);
      3'd4:    char_c = 8'h0D;
      default: char_c = 8'h0A;
    endcase
  end

  // Transmit FSM; tx/busy/count are registered and move on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snapshot_q  <= '0;
      last_sent_q <= '0;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      char_idx_q  <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trigger_c) begin
            snapshot_q  <= sync_sw;
            last_sent_q <= sync_sw;
            state_q     <= START;
            char_idx_q  <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b1;
            tx_q        <= 1'b0;
          end
        end
        START: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= char_c[0];
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= next_bit_c;
              tx_q      <= char_c[next_bit_c];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (char_idx_q < LAST_CHAR) begin
              // Next character starts immediately, no idle gap.
              char_idx_q <= char_idx_q + 3'd1;
              state_q    <= START;
              tx_q       <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= cnt_q + 8'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_sw_hex_uart_tx.sv
// Directed bench for sw_hex_uart_tx with CLKS_PER_BIT=4, SYNC_STAGES=2.
// A UART receiver task samples tx on falling clock edges and decodes frames.
module tb_sw_hex_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic        send;
  logic        tx;
  logic        busy;
  logic [7:0]  sent_count;

  int vec  = 0;
  int miss = 0;

  // Receiver results
  int          r_lat;
  logic [47:0] r_got;
  int          r_busy;
  bit          r_tmg;

  sw_hex_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .send(send),
    .tx(tx), .busy(busy), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a start bit, then decodes six back-to-back characters.
  // r_lat counts falling edges from the call up to the first start-bit sample.
  task automatic recv_frame();
    int n;
    logic v;
    logic [7:0] ch_v;
    r_lat = 0; r_got = '0; r_busy = 0; r_tmg = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 2000);
    r_lat = n;
    if (tx !== 1'b0) begin
      r_tmg = 1'b0;
      return;
    end
    for (int ch = 0; ch < 6; ch++) begin
      ch_v = '0;
      for (int b = 0; b < 10; b++) begin
        v = 1'b0;
        for (int c = 0; c < CPB; c++) begin
          if (!(ch == 0 && b == 0 && c == 0)) @(negedge clk);
          if (busy === 1'b1) r_busy++;
          if (c == 0) v = tx;
          else if (tx !== v) r_tmg = 1'b0;
        end
        if (b == 0 && v !== 1'b0) r_tmg = 1'b0;
        if (b == 9 && v !== 1'b1) r_tmg = 1'b0;
        if (b >= 1 && b <= 8) ch_v[b-1] = v;
      end
      r_got[(5-ch)*8 +: 8] = ch_v;
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0; sw = 16'h0000; send = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (tx !== 1'b1) begin miss++; $display("FAIL reset_tx got=%b exp=1", tx); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vec++; if (sent_count !== 8'd0) begin miss++; $display("FAIL reset_cnt got=%0d exp=0", sent_count); end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || sent_count !== 8'd0) bad = 1'b1;
    end
    vec++; if (bad) begin miss++; $display("FAIL quiet_idle got=activity exp=tx1_busy0_cnt0"); end
  endtask

  task automatic test_single();
    @(negedge clk);
    sw = 16'hA5C3;
    recv_frame();
    vec++; if (r_lat !== 3) begin miss++; $display("FAIL a5c3_latency got=%0d exp=3", r_lat); end
    vec++; if (r_got !== 48'h41_35_43_33_0D_0A) begin miss++; $display("FAIL a5c3_chars got=%h exp=413543330d0a", r_got); end
    vec++; if (!r_tmg) begin miss++; $display("FAIL a5c3_bit_timing got=bad exp=4cyc_bits"); end
    vec++; if (r_busy !== 60*CPB) begin miss++; $display("FAIL a5c3_busy_len got=%0d exp=%0d", r_busy, 60*CPB); end
    @(negedge clk);
    vec++; if (busy !== 1'b0 || tx !== 1'b1) begin miss++; $display("FAIL a5c3_end got=busy%b_tx%b exp=busy0_tx1", busy, tx); end
    vec++; if (sent_count !== 8'd1) begin miss++; $display("FAIL a5c3_cnt got=%0d exp=1", sent_count); end
  endtask

  task automatic test_send();
    bit bad;
    // Bring last_sent back to zero first.
    sw = 16'h0000;
    recv_frame();
    vec++; if (r_got !== 48'h30_30_30_30_0D_0A) begin miss++; $display("FAIL zero_chars got=%h exp=303030300d0a", r_got); end
    repeat (5) @(negedge clk);
    vec++; if (sent_count !== 8'd2) begin miss++; $display("FAIL zero_cnt got=%0d exp=2", sent_count); end
    send = 1'b1;
    fork
      recv_frame();
      begin
        @(negedge clk); send = 1'b0;
        repeat (100) @(negedge clk);
        send = 1'b1;
        @(negedge clk); send = 1'b0;
      end
    join
    vec++; if (r_lat !== 1) begin miss++; $display("FAIL send_latency got=%0d exp=1", r_lat); end
    vec++; if (r_got !== 48'h30_30_30_30_0D_0A) begin miss++; $display("FAIL send_chars got=%h exp=303030300d0a", r_got); end
    vec++; if (!r_tmg) begin miss++; $display("FAIL send_bit_timing got=bad exp=4cyc_bits"); end
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    vec++; if (bad) begin miss++; $display("FAIL send_not_queued got=extra_frame exp=idle"); end
    vec++; if (sent_count !== 8'd3) begin miss++; $display("FAIL send_cnt got=%0d exp=3", sent_count); end
  endtask

  task automatic test_midframe();
    bit bad;
    @(negedge clk);
    sw = 16'h1111;
    fork
      recv_frame();
      begin
        repeat (60) @(negedge clk); sw = 16'h2222;
        repeat (100) @(negedge clk); sw = 16'h3BEF;
      end
    join
    vec++; if (r_got !== 48'h31_31_31_31_0D_0A) begin miss++; $display("FAIL mid_first_chars got=%h exp=313131310d0a", r_got); end
    @(negedge clk);
    vec++; if (busy !== 1'b0 || tx !== 1'b1) begin miss++; $display("FAIL mid_gap got=busy%b_tx%b exp=busy0_tx1", busy, tx); end
    recv_frame();
    vec++; if (r_lat !== 1) begin miss++; $display("FAIL mid_gap_len got=%0d exp=1", r_lat); end
    vec++; if (r_got !== 48'h33_42_45_46_0D_0A) begin miss++; $display("FAIL mid_second_chars got=%h exp=334245460d0a", r_got); end
    vec++; if (!r_tmg) begin miss++; $display("FAIL mid_bit_timing got=bad exp=4cyc_bits"); end
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    vec++; if (bad) begin miss++; $display("FAIL mid_no_2222 got=extra_frame exp=idle"); end
    vec++; if (sent_count !== 8'd5) begin miss++; $display("FAIL mid_cnt got=%0d exp=5", sent_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sw = 16'h1234;
    // Start bit at 3 falling edges, char index 2 spans 80..119 cycles in.
    repeat (3 + 95) @(negedge clk);
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    sw = 16'hFFFF;
    #1;
    vec++; if (tx !== 1'b1) begin miss++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vec++; if (sent_count !== 8'd0) begin miss++; $display("FAIL rstmid_cnt got=%0d exp=0", sent_count); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    recv_frame();
    vec++; if (r_lat !== 3) begin miss++; $display("FAIL rstmid_latency got=%0d exp=3", r_lat); end
    vec++; if (r_got !== 48'h46_46_46_46_0D_0A) begin miss++; $display("FAIL rstmid_chars got=%h exp=464646460d0a", r_got); end
    @(negedge clk);
    vec++; if (sent_count !== 8'd1) begin miss++; $display("FAIL rstmid_cnt_after got=%0d exp=1", sent_count); end
  endtask

  task automatic test_count_wrap();
    int n;
    bit tmo;
    @(negedge clk);
    rst_n = 1'b0;
    sw = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tmo = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) tmo = 1'b1;
      if (k == 255) begin
        vec++; if (sent_count !== 8'd255) begin miss++; $display("FAIL wrap_cnt255 got=%0d exp=255", sent_count); end
      end
    end
    vec++; if (tmo) begin miss++; $display("FAIL wrap_busy_timeout got=stuck exp=busy_falls"); end
    vec++; if (sent_count !== 8'd0) begin miss++; $display("FAIL wrap_cnt0 got=%0d exp=0", sent_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_send();
    test_midframe();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
